// File: rtl/mul32_shift_add_if.sv
// Start/done handshake and operand/result bus for mul32_shift_add.
// master: the requester driving operands; slave: the multiplier.
interface mul32_shift_add_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input result);
    modport slave  (input  start, input  a,  input  b,
                    output busy,  output done, output result);
endinterface

// File: rtl/mul32_shift_add.sv
// Sequential 32x32->64 unsigned shift-and-add multiplier.
// One add-and-shift iteration per clock through a single cla32 adder.
// Optional build macro MUL32_EARLY_TERM_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (result is identical either way).

// 32-bit adder with 4-bit carry-lookahead groups chained by group carries.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = ci;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k]   = &p[B+3:B];
        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
        assign c[B]    = gc[k];
        assign c[B+1]  = g[B] | (p[B] & gc[k]);
        assign c[B+2]  = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3]  = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign s  = p ^ c;
    assign co = gc[8];
endmodule

module mul32_shift_add (
    input  logic             clk,
    input  logic             reset_n,
    mul32_shift_add_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic [31:0] mq;
    logic [5:0]  cnt;
    logic [63:0] result_q;

    logic [31:0] cla_s;
    logic        cla_co;
    logic [63:0] prod_next;
    logic        early_exit;

    // Partial sum of the upper product half and the multiplicand.
    cla32 u_cla (
        .a  (prod[63:32]),
        .b  (mcand),
        .ci (1'b0),
        .s  (cla_s),
        .co (cla_co)
    );

`ifdef MUL32_EARLY_TERM_EN
    // No multiplier bits left to consume: the remaining shifts only move zeros.
    assign early_exit = (mq == 32'h0);
`else
    assign early_exit = 1'b0;
`endif

    // Add-if-lsb-set then shift right; the adder carry becomes the new P[63].
    always_comb begin
        prod_next = {1'b0, prod[63:1]};
        if (prod[0]) begin
            prod_next = {cla_co, cla_s, prod[31:1]};
        end
    end

    // Control FSM plus the iterating product/multiplier registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mcand    <= 32'h0;
            prod     <= 64'h0;
            mq       <= 32'h0;
            cnt      <= 6'd0;
            result_q <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        prod  <= {32'h0, bus.b};
                        mq    <= bus.b;
                        cnt   <= 6'd32;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (early_exit) begin
                        // Low cnt bits of prod are the unconsumed (all-zero) multiplier bits.
                        result_q <= prod >> cnt;
                        state    <= DONE;
                    end else begin
                        prod <= prod_next;
                        mq   <= mq >> 1;
                        cnt  <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            result_q <= prod_next;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule
